// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: access-size and owner encodings plus the in-flight tag layout shared by the RAM arbiter.
package ram_arb_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
        logic       err;
    } tag_t;
endpackage

// File: rtl/ram_lane_align.sv
// ram_lane_align: byte-lane write enables and store shifting, plus load extraction and sign/zero extension.
module ram_lane_align
    import ram_arb_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [3:0]  be_o,
    output logic [31:0] lane_o,
    output logic [31:0] ext_o
);
    logic [31:0] sh;

    always_comb begin
        sh     = data_i >> {off_i, 3'b000};
        lane_o = data_i << {off_i, 3'b000};
        be_o   = size_i == SZ_BYTE ? 4'b0001 << off_i : size_i == SZ_HALF ? 4'b0011 << off_i : 4'b1111;
        ext_o  = size_i == SZ_BYTE ? {{24{~unsigned_i & sh[7]}}, sh[7:0]} :
                 size_i == SZ_HALF ? {{16{~unsigned_i & sh[15]}}, sh[15:0]} : data_i;
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the byte-lane data RAM between instruction fetch and load/store.
// Define RAM_ARB_RR_EN for round-robin read arbitration; otherwise LS has fixed priority over IF.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RAM_ADDR_BITS = 14
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    input  logic        if_flush,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_req_we,
    input  logic [1:0]  ls_req_size,
    input  logic        ls_req_unsigned,
    input  logic [31:0] ls_req_addr,
    input  logic [31:0] ls_req_wdata,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_rdata,
    output logic        ls_rsp_err,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_w_addr,
    output logic [31:0] ram_w_data,
    output logic        ram_ren,
    output logic [31:0] ram_r_addr,
    input  logic [31:0] ram_r_data
);
    tag_t        if_q, if_d, ls_q, ls_d;
    logic        if_err, ls_err, if_rd, ls_rd, ls_st, contested, hazard, ls_win;
    logic        if_rd_go, ls_rd_go, st_go, rd_if, if_data_ok;
    logic [3:0]  st_be, ld_be_unused;
    logic [31:0] st_lane, st_ext_unused, ld_lane_unused, ld_ext;

    assign if_err = (|if_req_addr[1:0]) | (|if_req_addr[31:RAM_ADDR_BITS]);
    assign ls_err = (ls_req_size == SZ_ILL) | (ls_req_size == SZ_HALF & ls_req_addr[0]) |
                    (ls_req_size == SZ_WORD & (|ls_req_addr[1:0])) | (|ls_req_addr[31:RAM_ADDR_BITS]);
    assign if_rd     = if_req_valid & ~if_err;
    assign ls_rd     = ls_req_valid & ~ls_err & ~ls_req_we;
    assign ls_st     = ls_req_valid & ~ls_err & ls_req_we;
    assign contested = if_rd & ls_rd;
    // the RAM's read-during-write ordering is not relied on, so a same-word fetch waits a cycle
    assign hazard    = if_rd & ls_st & (if_req_addr[31:2] == ls_req_addr[31:2]);

`ifdef RAM_ARB_RR_EN
    owner_e rr_q, rr_d;
    assign ls_win = ~contested | (rr_q == OWN_LS);
    assign rr_d   = contested ? (ls_win ? OWN_IF : OWN_LS) : rr_q;
    always_ff @(posedge sys_clk) rr_q <= sys_rst ? OWN_LS : rr_d;
`else
    assign ls_win = 1'b1;
`endif

    assign if_req_ready = ~sys_rst & if_req_valid & ~hazard & ~(contested & ls_win);
    assign ls_req_ready = ~sys_rst & ls_req_valid & (~ls_rd | ls_win);
    assign if_rd_go     = if_req_ready & if_rd;
    assign ls_rd_go     = ls_req_ready & ls_rd;
    assign st_go        = ls_req_ready & ls_st;

    assign ram_ren    = if_rd_go | ls_rd_go;
    assign ram_r_addr = ls_rd_go ? {ls_req_addr[31:2], 2'b00} : if_rd_go ? {if_req_addr[31:2], 2'b00} : 32'h0;
    assign ram_wen    = st_go ? st_be : 4'b0000;
    assign ram_w_addr = st_go ? {ls_req_addr[31:2], 2'b00} : 32'h0;
    assign ram_w_data = st_go ? st_lane : 32'h0;

    always_comb begin
        if_d       = '0;
        if_d.valid = if_req_ready & ~if_flush;
        if_d.size  = SZ_WORD;
        if_d.err   = if_err;
        ls_d       = '0;
        ls_d.valid = ls_req_ready;
        ls_d.we    = ls_req_we;
        ls_d.size  = ls_req_size;
        ls_d.uns   = ls_req_unsigned;
        ls_d.off   = ls_req_addr[1:0];
        ls_d.err   = ls_err;
    end

    always_ff @(posedge sys_clk) begin
        if_q <= sys_rst ? '0 : if_d;
        ls_q <= sys_rst ? '0 : ls_d;
    end

    ram_lane_align u_st (
        .size_i(ls_req_size), .unsigned_i(1'b0), .off_i(ls_req_addr[1:0]), .data_i(ls_req_wdata),
        .be_o(st_be), .lane_o(st_lane), .ext_o(st_ext_unused)
    );

    // only one read is ever in flight, so the load aligner follows whichever tag owns it
    assign rd_if = if_q.valid & ~if_q.err;
    ram_lane_align u_ld (
        .size_i(rd_if ? if_q.size : ls_q.size), .unsigned_i(rd_if ? if_q.uns : ls_q.uns),
        .off_i(rd_if ? if_q.off : ls_q.off), .data_i(ram_r_data),
        .be_o(ld_be_unused), .lane_o(ld_lane_unused), .ext_o(ld_ext)
    );

    assign if_rsp_valid = ~sys_rst & if_q.valid & ~if_flush;
    assign if_rsp_err   = if_rsp_valid & if_q.err;
    assign if_data_ok   = if_rsp_valid & ~if_q.err & ~if_q.we;
    assign if_rsp_data  = if_data_ok ? ld_ext : 32'h0;
    assign ls_rsp_valid = ~sys_rst & ls_q.valid;
    assign ls_rsp_err   = ls_rsp_valid & ls_q.err;
    assign ls_rsp_rdata = (ls_rsp_valid & ~ls_q.err & ~ls_q.we) ? ld_ext : 32'h0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a byte-array reference model and a simple RAM.
module tb_ram_arbiter;
    logic        clk = 0, sys_rst = 1;
    logic        if_req_valid = 0, if_req_ready, if_flush = 0, if_rsp_valid, if_rsp_err;
    logic [31:0] if_req_addr = 0, if_rsp_data;
    logic        ls_req_valid = 0, ls_req_ready, ls_req_we = 0, ls_req_unsigned = 0, ls_rsp_valid, ls_rsp_err;
    logic [1:0]  ls_req_size = 0;
    logic [31:0] ls_req_addr = 0, ls_req_wdata = 0, ls_rsp_rdata;
    logic [3:0]  ram_wen;
    logic [31:0] ram_w_addr, ram_w_data, ram_r_addr, ram_r_data;
    logic        ram_ren, ram_clr = 1;

    typedef struct packed {logic [31:0] d; logic e;} rsp_t;
    rsp_t ifq[$], lsq[$], pend, mr;
    logic pend_v = 0, ls_turn = 1;
    int   errors = 0, checks = 0;
    logic [7:0] ram [0:1023];
    logic [7:0] rmem[0:1023];

    always #5 clk = ~clk;

    ram_arbiter dut (
        .sys_clk(clk), .sys_rst(sys_rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr), .if_flush(if_flush),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we), .ls_req_size(ls_req_size),
        .ls_req_unsigned(ls_req_unsigned), .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata), .ls_rsp_err(ls_rsp_err),
        .ram_wen(ram_wen), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_ren(ram_ren), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );

    // environment RAM: one-cycle read latency, byte write enables
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'h0;
            ram_r_data <= 32'h0;
        end else begin
            if (ram_ren)
                ram_r_data <= {ram[{ram_r_addr[9:2], 2'd3}], ram[{ram_r_addr[9:2], 2'd2}],
                               ram[{ram_r_addr[9:2], 2'd1}], ram[{ram_r_addr[9:2], 2'd0}]};
            for (int i = 0; i < 4; i++)
                if (ram_wen[i]) ram[{ram_w_addr[9:2], 2'(i)}] <= ram_w_data[8*i+:8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bad_ls(input logic [1:0] sz, input logic [31:0] a);
        return sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || a >= 32'h4000;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        int b = int'(a[9:0]) & ~3;
        return {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
    endfunction

    function automatic logic [31:0] ld_val(input logic [1:0] sz, input logic u, input logic [31:0] a);
        int b = int'(a[9:0]);
        logic [15:0] h = {rmem[b+1], rmem[b]};
        if (sz == 2'd0) return u ? {24'h0, rmem[b]} : {{24{rmem[b][7]}}, rmem[b]};
        if (sz == 2'd1) return u ? {16'h0, h} : {{16{h[15]}}, h};
        return word_at(a);
    endfunction

    // one bus cycle: drive, predict grants and RAM port activity, queue the expected responses
    task automatic cyc(input logic r, iv, input logic [31:0] ia, input logic fl,
                       input logic lv, lw, input logic [1:0] lz, input logic lu, input logic [31:0] la, lwd);
        logic ib, lb, ifr, lsr, lss, hz, con, lwin, ri, rl, eren;
        logic [3:0]  ewen;
        logic [31:0] ewa, ewd, era;
        @(posedge clk); #1;
        sys_rst = r; if_req_valid = iv; if_req_addr = ia; if_flush = fl;
        ls_req_valid = lv; ls_req_we = lw; ls_req_size = lz; ls_req_unsigned = lu; ls_req_addr = la; ls_req_wdata = lwd;
        if (pend_v && !fl && !r) ifq.push_back(pend);
        pend_v = 0;
        #1;
        ib  = ia[1:0] != 2'd0 || ia >= 32'h4000;
        lb  = bad_ls(lz, la);
        ifr = iv && !ib;
        lsr = lv && !lw && !lb;
        lss = lv && lw && !lb;
        hz  = ifr && lss && ia[31:2] == la[31:2];
        con = ifr && lsr;
`ifdef RAM_ARB_RR_EN
        lwin = ls_turn;
`else
        lwin = 1'b1;
`endif
        rl = !r && lv && (!con || lwin);
        ri = !r && iv && !hz && !(con && lwin);
        if (r) begin
            ifq.delete(); lsq.delete(); ls_turn = 1;
        end else if (con) ls_turn = !ls_turn;
        ewen = 0; ewa = 0; ewd = 0; eren = 0; era = 0;
        if (ri && ifr) begin eren = 1; era = {ia[31:2], 2'b00}; end
        if (rl && lsr) begin eren = 1; era = {la[31:2], 2'b00}; end
        if (ri && !fl) begin pend_v = 1; pend = ib ? {32'h0, 1'b1} : {word_at(ia), 1'b0}; end
        if (rl) begin
            if (lb) lsq.push_back({32'h0, 1'b1});
            else if (!lw) lsq.push_back({ld_val(lz, lu, la), 1'b0});
            else begin
                lsq.push_back({32'h0, 1'b0});
                ewa = {la[31:2], 2'b00};
                ewd = lwd << (8 * la[1:0]);
                for (int i = 0; i < (1 << lz); i++) begin
                    ewen[int'(la[1:0]) + i] = 1'b1;
                    rmem[int'(la[9:0]) + i] = lwd[8*i+:8];
                end
            end
        end
        chk("if_ready", {31'h0, if_req_ready}, {31'h0, ri});
        chk("ls_ready", {31'h0, ls_req_ready}, {31'h0, rl});
        chk("ram_wen", {28'h0, ram_wen}, {28'h0, ewen});
        chk("ram_w_addr", ram_w_addr, ewa);
        chk("ram_w_data", ram_w_data, ewd);
        chk("ram_ren", {31'h0, ram_ren}, {31'h0, eren});
        chk("ram_r_addr", ram_r_addr, era);
    endtask

    task automatic idle(input logic r);
        cyc(r, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ls(input logic w, input logic [1:0] z, input logic u, input logic [31:0] a, d);
        cyc(0, 0, 0, 0, 1, w, z, u, a, d);
    endtask

    always @(negedge clk) begin
        if (if_rsp_valid) begin
            if (ifq.size() == 0) begin
                errors++; checks++;
                $display("FAIL if_unexpected: got response data %h err %b, expected none", if_rsp_data, if_rsp_err);
            end else begin
                mr = ifq.pop_front();
                chk("if_rsp_data", if_rsp_data, mr.d);
                chk("if_rsp_err", {31'h0, if_rsp_err}, {31'h0, mr.e});
            end
        end
        if (ls_rsp_valid) begin
            if (lsq.size() == 0) begin
                errors++; checks++;
                $display("FAIL ls_unexpected: got response data %h err %b, expected none", ls_rsp_rdata, ls_rsp_err);
            end else begin
                mr = lsq.pop_front();
                chk("ls_rsp_rdata", ls_rsp_rdata, mr.d);
                chk("ls_rsp_err", {31'h0, ls_rsp_err}, {31'h0, mr.e});
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) rmem[i] = 8'h0;
        idle(1);
        ram_clr = 0;
        idle(1);
        @(negedge clk);
        chk("reset_outs", {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err, ram_ren, ram_wen}, 32'h0);
        idle(0);
        ls(1, 2, 0, 32'h10, 32'hDEADBEEF);
        ls(0, 2, 0, 32'h10, 0);
        ls(1, 0, 0, 32'h13, 32'h80);
        ls(0, 0, 0, 32'h13, 0);
        ls(0, 0, 1, 32'h13, 0);
        ls(1, 1, 0, 32'h12, 32'h8001);
        ls(0, 1, 0, 32'h12, 0);
        ls(0, 1, 0, 32'h11, 0);
        ls(0, 2, 0, 32'h4002, 0);
        ls(0, 2, 0, 32'h4000, 0);
        ls(1, 3, 0, 32'h14, 32'h55);
        cyc(0, 1, 32'h2, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h10, 0, 1, 0, 2, 0, 32'h10, 0);
        cyc(0, 1, 32'h20, 0, 1, 1, 2, 0, 32'h20, 32'h12345678);
        cyc(0, 1, 32'h20, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h20, 0, 1, 1, 2, 0, 32'h24, 32'hCAFEF00D);
        cyc(0, 1, 32'h24, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h10, 1, 0, 0, 0, 0, 0, 0);
        idle(0);
        cyc(0, 1, 32'h30, 0, 1, 1, 2, 0, 32'h40, 32'h11223344);
        cyc(1, 1, 32'h30, 0, 1, 0, 2, 0, 32'h44, 0);
        @(negedge clk);
        chk("rst_flags", {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err, ram_ren, ram_wen}, 32'h0);
        chk("rst_if_data", if_rsp_data, 32'h0);
        chk("rst_ls_data", ls_rsp_rdata, 32'h0);
        idle(0);
        ls(0, 2, 0, 32'h40, 0);
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ia, la;
            ia = 32'(($urandom % 16) * 4);
            la = 32'($urandom % 64);
            if ($urandom % 10 == 0) ia = ($urandom % 2) ? ia + 32'($urandom % 4) : 32'h4000;
            if ($urandom % 10 == 0) la = la | 32'h4000;
            cyc(($urandom % 100) == 0, 1'($urandom), ia, ($urandom % 8) == 0,
                1'($urandom), 1'($urandom), ($urandom % 8) == 0 ? 2'd3 : 2'($urandom % 3), 1'($urandom), la, $urandom);
        end
        idle(0);
        idle(0);
        idle(0);
        @(negedge clk);
        chk("if_left", ifq.size(), 0);
        chk("ls_left", lsq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
